// File: rtl/arm_pipe_pkg.sv
// ----------------------------------------------------------------------------
// arm_pipe_pkg
//   Shared definitions for the ARM 5-stage pipeline registers.
//   - Field widths of the decoded ID->EX bundle (ALU command, status,
//     shifter operand, branch immediate, control vector).
//   - Bit positions inside the 5-bit control vector
//     {status_en, mem_read, mem_write, wb_en, branch}.
//   - edge_act_e: the single action a pipeline register performs on a
//     rising clock edge.
// ----------------------------------------------------------------------------
package arm_pipe_pkg;

    localparam int unsigned ALU_CMD_W  = 4;
    localparam int unsigned STATUS_W   = 4;
    localparam int unsigned SHIFT_OP_W = 12;
    localparam int unsigned BIMM_W     = 24;
    localparam int unsigned CTRL_W     = 5;

    localparam int unsigned CTRL_STATUS_EN = 4;
    localparam int unsigned CTRL_MEM_READ  = 3;
    localparam int unsigned CTRL_MEM_WRITE = 2;
    localparam int unsigned CTRL_WB_EN     = 1;
    localparam int unsigned CTRL_BRANCH    = 0;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2,
        RESET  = 2'd3
    } edge_act_e;

endpackage

// File: rtl/pipe_field_reg.sv
// ----------------------------------------------------------------------------
// pipe_field_reg
//   One field group of a pipeline register. Priority per rising edge:
//   rst > clear > hold > load.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset, q <= 0
//     hold   in   keep current value
//     clear  in   load zero (pipeline bubble)
//     d      in   W-bit next value
//     q      out  W-bit registered value
// ----------------------------------------------------------------------------
module pipe_field_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (clear) begin
            q_q <= '0;
        end else if (!hold) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID->EX pipeline register of the ARM 5-stage core with hazard freeze,
//   branch flush (bubble), valid bit and control gating for invalid slots.
//   Priority per edge: rst > flush > freeze > load.
//
//   Optional: define ID_EX_PERF_EN to add saturating occupancy counters
//   (bubble_cnt, stall_cnt). Without it those ports and logic are absent.
//
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     freeze                hazard stall: hold every output
//     flush                 branch taken: load a bubble (all zeros)
//     valid_in              ID slot holds a real instruction
//     pc_in, reg1_in, reg2_in          DATA_W data fields
//     src1_in, src2_in, dest_in        REG_ADDR_W register indices
//     alu_cmd_in, status_in            4-bit ALU command / NZCV
//     ctrl_in               {status_en, mem_read, mem_write, wb_en, branch}
//     imm_in, shifter_operand_in, b_signed_imm_in   immediates
//     *_out                 registered copies, valid_out
//     bubble_cnt, stall_cnt CNT_W counters (ID_EX_PERF_EN only)
// ----------------------------------------------------------------------------
module id_ex_pipe_reg
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
`ifdef ID_EX_PERF_EN
    ,
    parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     reg1_in,
    input  logic [DATA_W-1:0]     reg2_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [ALU_CMD_W-1:0]  alu_cmd_in,
    input  logic [STATUS_W-1:0]   status_in,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] shifter_operand_in,
    input  logic [BIMM_W-1:0]     b_signed_imm_in,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     reg1_out,
    output logic [DATA_W-1:0]     reg2_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [ALU_CMD_W-1:0]  alu_cmd_out,
    output logic [STATUS_W-1:0]   status_out,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] shifter_operand_out,
    output logic [BIMM_W-1:0]     b_signed_imm_out,
    output logic                  valid_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    localparam int unsigned DATA_GRP_W = 3 * DATA_W;
    localparam int unsigned IDX_GRP_W  = 3 * REG_ADDR_W;
    localparam int unsigned OP_GRP_W   = ALU_CMD_W + STATUS_W + 1 + SHIFT_OP_W + BIMM_W;
    localparam int unsigned CTL_GRP_W  = CTRL_W + 1;

    edge_act_e act;
    logic      hold;
    logic      clear;
    logic [CTRL_W-1:0] ctrl_d;

    always_comb begin
        act = LOAD;
        if (rst) begin
            act = RESET;
        end else if (flush) begin
            act = BUBBLE;
        end else if (freeze) begin
            act = HOLD;
        end
    end

    assign hold  = (act == HOLD);
    assign clear = (act == BUBBLE);

    // An invalid slot must not write back, touch memory, update flags or branch.
    always_comb begin
        ctrl_d                 = '0;
        ctrl_d[CTRL_STATUS_EN] = ctrl_in[CTRL_STATUS_EN] & valid_in;
        ctrl_d[CTRL_MEM_READ]  = ctrl_in[CTRL_MEM_READ]  & valid_in;
        ctrl_d[CTRL_MEM_WRITE] = ctrl_in[CTRL_MEM_WRITE] & valid_in;
        ctrl_d[CTRL_WB_EN]     = ctrl_in[CTRL_WB_EN]     & valid_in;
        ctrl_d[CTRL_BRANCH]    = ctrl_in[CTRL_BRANCH]    & valid_in;
    end

    pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (clear),
        .d     ({pc_in, reg1_in, reg2_in}),
        .q     ({pc_out, reg1_out, reg2_out})
    );

    pipe_field_reg #(.W(IDX_GRP_W)) u_idx_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (clear),
        .d     ({src1_in, src2_in, dest_in}),
        .q     ({src1_out, src2_out, dest_out})
    );

    pipe_field_reg #(.W(OP_GRP_W)) u_op_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (clear),
        .d     ({alu_cmd_in, status_in, imm_in, shifter_operand_in, b_signed_imm_in}),
        .q     ({alu_cmd_out, status_out, imm_out, shifter_operand_out, b_signed_imm_out})
    );

    pipe_field_reg #(.W(CTL_GRP_W)) u_ctl_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (clear),
        .d     ({valid_in, ctrl_d}),
        .q     ({valid_out, ctrl_out})
    );

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        bubble_d = bubble_q;
        stall_d  = stall_q;
        case (act)
            BUBBLE: begin
                if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
            end
            LOAD: begin
                if (!valid_in && bubble_q != '1) bubble_d = bubble_q + 1'b1;
            end
            HOLD: begin
                if (stall_q != '1) stall_d = stall_q + 1'b1;
            end
            default: begin
                bubble_d = '0;
                stall_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
        end
    end

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;
`endif

endmodule
